// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : snn_pkg
//  Purpose  : Shared types, constants and helpers for the parametrised LIF
//             neuron (snn_lif_param) and its synaptic adder (snn_syn_sum).
//  Contents : lif_state_e  - neuron FSM state encoding {INTEG, REFRAC}
//             SNN_MEM_RST  - membrane value after reset / reset-to-zero fire
//             sat_add()    - signed add clamped to a 'width'-bit signed range
//  Revision : 1.0 - initial release
// ============================================================================
package snn_pkg;

  typedef enum logic [0:0] {
    INTEG  = 1'b0,
    REFRAC = 1'b1
  } lif_state_e;

  localparam int SNN_MEM_RST = 0;

  // Adds two signed operands at 64 bits (wide enough that the raw sum never
  // overflows for any supported membrane width), then clamps the result into
  // the signed range of a 'width'-bit number. Callers size-cast the result
  // down to 'width' bits, which is lossless after the clamp.
  function automatic logic signed [63:0] sat_add(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int unsigned        width
  );
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (s > hi) begin
      return hi;
    end else if (s < lo) begin
      return lo;
    end else begin
      return s;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/snn_syn_sum.sv
`default_nettype none
// ============================================================================
//  Module   : snn_syn_sum
//  Purpose  : Combinational weighted synaptic sum. Each signed weight is
//             gated by its spike bit, sign-extended to OUT_WIDTH and summed.
//  Ports    : spike_i   [N_IN]               input spike vector
//             weights_i [N_IN*WEIGHT_WIDTH]  packed signed weights,
//                                            weight i at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
//             sum_o     [OUT_WIDTH]          signed (two's complement) sum
//  Note     : OUT_WIDTH must be >= WEIGHT_WIDTH + $clog2(N_IN) so the full
//             sum is representable without overflow.
//  Revision : 1.0 - initial release
// ============================================================================
module snn_syn_sum
  import snn_pkg::*;
#(
  parameter int N_IN         = 4,
  parameter int WEIGHT_WIDTH = 4,
  parameter int OUT_WIDTH    = 8
) (
  input  logic [N_IN-1:0]              spike_i,
  input  logic [N_IN*WEIGHT_WIDTH-1:0] weights_i,
  output logic [OUT_WIDTH-1:0]         sum_o
);

  logic [OUT_WIDTH-1:0] w_term [N_IN];
  logic [OUT_WIDTH-1:0] w_acc;

  // Gate and sign-extend each weight so the accumulation below can use plain
  // two's complement addition.
  for (genvar gi = 0; gi < N_IN; gi++) begin : g_gate
    assign w_term[gi] = spike_i[gi]
                      ? OUT_WIDTH'(signed'(weights_i[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH]))
                      : '0;
  end

  always_comb begin
    w_acc = '0;
    for (int i = 0; i < N_IN; i++) begin
      w_acc = w_acc + w_term[i];
    end
  end

  assign sum_o = w_acc;

endmodule
`default_nettype wire

// File: rtl/snn_lif_param.sv
`default_nettype none
// ============================================================================
//  Module   : snn_lif_param
//  Purpose  : Parametrised leaky integrate-and-fire neuron with programmable
//             threshold, leak, refractory period, reset mode, saturating
//             membrane arithmetic and a timestep enable strobe.
//  Ports    : CLK, nRST (async active-low)
//             en          timestep strobe; state advances only when high
//             spike_in    [N_IN] input spikes (bit i gates weight i)
//             weights     [N_IN*WEIGHT_WIDTH] packed signed weights
//             threshold   [MEM_WIDTH] signed firing threshold
//             leak        [LEAK_WIDTH] unsigned per-timestep leak
//             refrac_len  [REFRAC_WIDTH] refractory timesteps (0 = none)
//             reset_mode  0 = reset to zero, 1 = subtract threshold
//             spike_out   registered one-CLK spike pulse
//             membrane    [MEM_WIDTH] signed membrane potential
//             refractory  high while in the refractory state
//  Config   : define SNN_LIF_FLOOR_CLAMP_EN to clamp the membrane at 0
//             instead of the signed minimum.
//  Revision : 1.0 - initial release
// ============================================================================
module snn_lif_param
  import snn_pkg::*;
#(
  parameter int N_IN         = 4,
  parameter int WEIGHT_WIDTH = 4,
  parameter int MEM_WIDTH    = 8,
  parameter int LEAK_WIDTH   = 3,
  parameter int REFRAC_WIDTH = 3
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         en,
  input  logic [N_IN-1:0]              spike_in,
  input  logic [N_IN*WEIGHT_WIDTH-1:0] weights,
  input  logic [MEM_WIDTH-1:0]         threshold,
  input  logic [LEAK_WIDTH-1:0]        leak,
  input  logic [REFRAC_WIDTH-1:0]      refrac_len,
  input  logic                         reset_mode,
  output logic                         spike_out,
  output logic [MEM_WIDTH-1:0]         membrane,
  output logic                         refractory
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  lif_state_e                     state_q, state_d;
  logic [REFRAC_WIDTH-1:0]        cnt_q, cnt_d;
  logic signed [MEM_WIDTH-1:0]    mem_q, mem_d;
  logic                           spike_q, spike_d;

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  logic [MEM_WIDTH-1:0]           w_sum;
  logic signed [MEM_WIDTH-1:0]    w_thr;
  logic signed [MEM_WIDTH-1:0]    w_v_sat;
  logic signed [MEM_WIDTH-1:0]    w_v;
  logic signed [MEM_WIDTH-1:0]    w_sub_sat;
  logic signed [MEM_WIDTH-1:0]    w_sub;
  logic                           w_fire;

  snn_syn_sum #(
    .N_IN         (N_IN),
    .WEIGHT_WIDTH (WEIGHT_WIDTH),
    .OUT_WIDTH    (MEM_WIDTH)
  ) u_syn_sum (
    .spike_i   (spike_in),
    .weights_i (weights),
    .sum_o     (w_sum)
  );

  assign w_thr = signed'(threshold);

  // membrane + sum - leak, evaluated wide and clamped to the membrane range.
  // Leak is unsigned, so it is zero-extended before negation.
  assign w_v_sat = MEM_WIDTH'(sat_add(64'(mem_q) + 64'(signed'(w_sum)),
                                      -64'(leak), MEM_WIDTH));

  // Subtract-threshold reset value, again clamped (a negative threshold can
  // push the residue above the positive limit).
  assign w_sub_sat = MEM_WIDTH'(sat_add(64'(w_v), -64'(w_thr), MEM_WIDTH));

`ifdef SNN_LIF_FLOOR_CLAMP_EN
  assign w_v   = (w_v_sat   < 0) ? '0 : w_v_sat;
  assign w_sub = (w_sub_sat < 0) ? '0 : w_sub_sat;
`else
  assign w_v   = w_v_sat;
  assign w_sub = w_sub_sat;
`endif

  // Fire decision uses the clamped potential, so a saturated membrane at the
  // positive limit still fires against a threshold equal to that limit.
  assign w_fire = (w_v >= w_thr);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    spike_d = 1'b0;

    if (en) begin
      case (state_q)
        INTEG: begin
          if (w_fire) begin
            spike_d = 1'b1;
            mem_d   = reset_mode ? w_sub : MEM_WIDTH'(SNN_MEM_RST);
            if (refrac_len != '0) begin
              cnt_d   = refrac_len;
              state_d = REFRAC;
            end
          end else begin
            mem_d = w_v;
          end
        end

        REFRAC: begin
          // Membrane held, inputs and leak ignored. Exit on the edge where
          // the counter reaches zero so the period is exactly refrac_len
          // en-cycles. A zero count cannot be loaded, but exit anyway.
          cnt_d = cnt_q - REFRAC_WIDTH'(1);
          if (cnt_q <= REFRAC_WIDTH'(1)) begin
            cnt_d   = '0;
            state_d = INTEG;
          end
        end

        default: begin
          state_d = INTEG;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= INTEG;
      cnt_q   <= '0;
      mem_q   <= MEM_WIDTH'(SNN_MEM_RST);
      spike_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
      spike_q <= spike_d;
    end
  end

  assign spike_out  = spike_q;
  assign membrane   = mem_q;
  assign refractory = (state_q == REFRAC);

endmodule
`default_nettype wire

// File: tb/tb_snn_lif_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_snn_lif_param
//  Purpose  : Directed self-checking bench for snn_lif_param (default
//             parameters: N_IN=4, WEIGHT_WIDTH=4, MEM_WIDTH=8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_snn_lif_param;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        en;
  logic [3:0]  spike_in;
  logic [15:0] weights;
  logic [7:0]  threshold;
  logic [2:0]  leak;
  logic [2:0]  refrac_len;
  logic        reset_mode;
  logic        spike_out;
  logic [7:0]  membrane;
  logic        refractory;

  int tests = 0;
  int fails = 0;

  snn_lif_param dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .en         (en),
    .spike_in   (spike_in),
    .weights    (weights),
    .threshold  (threshold),
    .leak       (leak),
    .refrac_len (refrac_len),
    .reset_mode (reset_mode),
    .spike_out  (spike_out),
    .membrane   (membrane),
    .refractory (refractory)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    #2 nRST = 1'b0;
    #2 nRST = 1'b1;
  endtask

  function automatic logic signed [31:0] mem_s();
    return 32'($signed(membrane));
  endfunction

  initial begin
    nRST       = 1'b0;
    en         = 1'b0;
    spike_in   = 4'hF;
    weights    = 16'h1111;
    threshold  = 8'd10;
    leak       = 3'd0;
    refrac_len = 3'd0;
    reset_mode = 1'b0;

    // ---------------- reset state ----------------
    tick(); tick();
    chk("rst_mem", mem_s(), 0);
    chk("rst_spike", 32'(spike_out), 0);
    chk("rst_refr", 32'(refractory), 0);
    #2 nRST = 1'b1;

    // ---------------- 1: basic integrate & fire, reset to zero -------------
    en = 1'b1;
    tick(); chk("t1_mem1", mem_s(), 4);  chk("t1_spk1", 32'(spike_out), 0);
    tick(); chk("t1_mem2", mem_s(), 8);
    tick(); chk("t1_fire", 32'(spike_out), 1); chk("t1_mem0", mem_s(), 0);
    en = 1'b0;
    tick(); chk("t1_pulse", 32'(spike_out), 0); chk("t1_hold", mem_s(), 0);

    // ---------------- 2: subtract-threshold reset ----------------
    reset_mode = 1'b1;
    en = 1'b1;
    tick(); tick();
    tick(); chk("t2_fire1", 32'(spike_out), 1); chk("t2_res", mem_s(), 2);
    tick(); chk("t2_mem6", mem_s(), 6); chk("t2_nofire", 32'(spike_out), 0);
    tick(); chk("t2_fire2", 32'(spike_out), 1); chk("t2_mem0", mem_s(), 0);

    // ---------------- 3: refractory period of 3 ----------------
    reset_mode = 1'b0;
    refrac_len = 3'd3;
    tick(); tick();
    tick(); chk("t3_fire", 32'(spike_out), 1); chk("t3_refr0", 32'(refractory), 1);
    refrac_len = 3'd7;  // must not affect the count already loaded
    tick(); chk("t3_refr1", 32'(refractory), 1); chk("t3_held1", mem_s(), 0);
    chk("t3_spk1", 32'(spike_out), 0);
    tick(); chk("t3_refr2", 32'(refractory), 1); chk("t3_held2", mem_s(), 0);
    tick(); chk("t3_exit", 32'(refractory), 0); chk("t3_held3", mem_s(), 0);
    refrac_len = 3'd0;
    tick(); chk("t3_integ", mem_s(), 4);

    // ---------------- 4: negative saturation ----------------
    en = 1'b0;
    weights   = 16'h8888;
    leak      = 3'd7;
    threshold = 8'd127;
    do_reset();
    en = 1'b1;
`ifdef SNN_LIF_FLOOR_CLAMP_EN
    tick(); chk("t4_s1", mem_s(), 0);
    tick(); chk("t4_s2", mem_s(), 0);
    tick(); chk("t4_s3", mem_s(), 0);
    tick(); chk("t4_s4", mem_s(), 0);
    repeat (6) tick();
    chk("t4_s10", mem_s(), 0);
`else
    tick(); chk("t4_s1", mem_s(), -39);
    tick(); chk("t4_s2", mem_s(), -78);
    tick(); chk("t4_s3", mem_s(), -117);
    tick(); chk("t4_s4", mem_s(), -128);
    repeat (6) tick();
    chk("t4_s10", mem_s(), -128);
`endif
    chk("t4_nospk", 32'(spike_out), 0);

    // ---------------- 5: positive saturation fires at 127 ----------------
    en = 1'b0;
    weights = 16'h7777;
    leak    = 3'd0;
    do_reset();
    en = 1'b1;
    tick(); chk("t5_m1", mem_s(), 28);
    tick(); tick();
    tick(); chk("t5_m4", mem_s(), 112); chk("t5_nospk", 32'(spike_out), 0);
    tick(); chk("t5_fire", 32'(spike_out), 1); chk("t5_mem0", mem_s(), 0);
    // subtract mode: clamped 127 - 127 = 0, never wraps negative
    reset_mode = 1'b1;
    repeat (4) tick();
    tick(); chk("t5_fire_sub", 32'(spike_out), 1); chk("t5_sub0", mem_s(), 0);
    reset_mode = 1'b0;

    // ---------------- zero threshold, no input: fires every step ----------
    spike_in  = 4'h0;
    threshold = 8'd0;
    tick(); chk("thr0_a", 32'(spike_out), 1);
    tick(); chk("thr0_b", 32'(spike_out), 1); chk("thr0_mem", mem_s(), 0);

    // ---------------- 6: en toggling and async reset ----------------
    en         = 1'b0;
    spike_in   = 4'hF;
    weights    = 16'h1111;
    threshold  = 8'd10;
    refrac_len = 3'd3;
    do_reset();
    en = 1'b1; tick(); chk("t6_m4", mem_s(), 4);
    en = 1'b0; tick(); chk("t6_hold4", mem_s(), 4);
    en = 1'b1; tick(); chk("t6_m8", mem_s(), 8);
    en = 1'b0; tick(); chk("t6_hold8", mem_s(), 8);
    en = 1'b1; tick(); chk("t6_fire", 32'(spike_out), 1); chk("t6_refr", 32'(refractory), 1);
    en = 1'b0; tick(); chk("t6_pulse", 32'(spike_out), 0); chk("t6_refr_hold", 32'(refractory), 1);
    en = 1'b1; tick(); chk("t6_refr_a", 32'(refractory), 1);
    en = 1'b0; tick(); chk("t6_refr_b", 32'(refractory), 1);
    // async reset mid-refractory
    #2 nRST = 1'b0;
    #1 chk("t6_arst_refr", 32'(refractory), 0); chk("t6_arst_mem", mem_s(), 0);
    #1 nRST = 1'b1;
    // async reset mid-pulse
    refrac_len = 3'd0;
    en = 1'b1;
    tick(); tick(); tick();
    chk("t6_fire2", 32'(spike_out), 1);
    #2 nRST = 1'b0;
    #1 chk("t6_arst_spk", 32'(spike_out), 0); chk("t6_arst_mem2", mem_s(), 0);
    #1 nRST = 1'b1;
    en = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
